// File: rtl/sys_array_result_drain.sv
// sys_array_result_drain
// Snapshots all PE accumulator results (plus the array error flag) on a rising
// comp_done, then streams them row-major over a valid/ready interface. The
// array is free to start its next computation as soon as the snapshot is held.
module sys_array_result_drain #(
    parameter int M      = 2,
    parameter int K      = 2,
    parameter int DATA_W = 32
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 comp_done,
    input  logic                                 arr_error,
    input  logic [M*K*DATA_W-1:0]                res_in,
    output logic [DATA_W-1:0]                    out_dat,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] out_col,
    output logic                                 out_last,
    output logic                                 out_err,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 overrun
);

    localparam int N  = M * K;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] buf_q [N];
    logic [DATA_W-1:0] buf_d [N];
    logic              err_q, err_d;
    logic              comp_done_q;
    logic              overrun_q, overrun_d;

    logic done_rise;
    logic draining;
    logic at_last;
    logic xfer;

    assign done_rise = comp_done & ~comp_done_q;
    assign draining  = (state_q == DRAIN);
    assign at_last   = (idx_q == IW'(N - 1));
    assign xfer      = draining & out_ready;

    // Next-state logic: capture on a rise while idle or on the final handshake,
    // otherwise advance the read index and flag any rise that cannot be taken.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        buf_d     = buf_q;

        case (state_q)
            IDLE: begin
                if (done_rise) begin
                    for (int i = 0; i < N; i++) begin
                        buf_d[i] = res_in[i*DATA_W +: DATA_W];
                    end
                    err_d   = arr_error;
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && at_last) begin
                    idx_d = '0;
                    if (done_rise) begin
                        for (int i = 0; i < N; i++) begin
                            buf_d[i] = res_in[i*DATA_W +: DATA_W];
                        end
                        err_d = arr_error;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (done_rise) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State registers; comp_done_q resets high so a level already present at
    // reset release is not mistaken for a new completion.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            err_q       <= 1'b0;
            comp_done_q <= 1'b1;
            overrun_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            comp_done_q <= comp_done;
            overrun_q   <= overrun_d;
            buf_q       <= buf_d;
        end
    end

    // Output decode from registered state; everything reads zero outside DRAIN.
    always_comb begin
        out_valid = draining;
        busy      = draining;
        overrun   = overrun_q;
        out_dat   = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        if (draining) begin
            out_dat  = buf_q[idx_q];
            out_row  = RW'(int'(idx_q) / K);
            out_col  = CW'(int'(idx_q) % K);
            out_last = at_last;
            out_err  = err_q;
        end
    end

endmodule
